mdsr_op_sequencer: RTL and testbench

Operation sequencer for the shared 16-bit multiply/divide/square-root iterative core. Accepts one request at a time over a valid/ready handshake and conditions the operands. It launches the core with a start pulse, waits for its done strobe, and returns the result over a second valid/ready handshake. It sits between the top-level operand registers and the arithmetic core. It owns every core_start in the design.

---
 rtl/mdsr_op_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_mdsr_op_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdsr_op_sequencer.sv
// Operation sequencer for the shared multiply/divide/sqrt core: conditions operands,
// launches the core, and returns its result. Optional watchdog: define MDSR_TIMEOUT_EN.
module mdsr_op_sequencer #(
    parameter int DW        = 16,
    parameter int TO_CYCLES = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [DW-1:0] req_q,
    input  logic [DW-1:0] req_m,
    output logic          core_start,
    output logic [1:0]    core_op,
    output logic [DW-1:0] core_q,
    output logic [DW-1:0] core_m,
    input  logic          core_done,
    input  logic [DW-1:0] core_res_hi,
    input  logic [DW-1:0] core_res_lo,
    output logic          core_abort,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_hi,
    output logic [DW-1:0] rsp_lo,
    output logic [1:0]    rsp_err,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COND  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_SQRT  = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;
    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_ILL  = 2'b10;
    localparam int         TO_W     = $clog2(TO_CYCLES + 1);

    state_t        state_r;
    logic [1:0]    op_r;
    logic [DW-1:0] q_r;
    logic [DW-1:0] m_r;

    // Returns {core_q, core_m}; the most-negative squared product is remapped
    // before the zero-multiplier swap so that corner case never reaches the core.
    function automatic logic [2*DW-1:0] cond_operands(
        input logic [1:0]    op,
        input logic [DW-1:0] q,
        input logic [DW-1:0] m
    );
        logic [DW-1:0]   min_neg;
        logic [DW-1:0]   one;
        logic [2*DW-1:0] res;
        min_neg = {1'b1, {(DW-1){1'b0}}};
        one     = {{(DW-1){1'b0}}, 1'b1};
        case (op)
            OP_MUL: begin
                if ((q == min_neg) && (m == min_neg)) begin
                    res = {one, one};
                end else if (m == {DW{1'b0}}) begin
                    res = {m, q};
                end else begin
                    res = {q, m};
                end
            end
            OP_SQRT: res = {q, {DW{1'b0}}};
            default: res = {q, m};
        endcase
        return res;
    endfunction

`ifdef MDSR_TIMEOUT_EN
    localparam logic [1:0] ERR_TO = 2'b11;
    logic [TO_W-1:0] to_cnt_r;
    logic            core_abort_r;
    assign core_abort = core_abort_r;
`else
    logic [TO_W-1:0] unused_to_s;
    assign unused_to_s = TO_W'(TO_CYCLES);
    assign core_abort  = 1'b0;
`endif

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            op_r       <= 2'b00;
            q_r        <= {DW{1'b0}};
            m_r        <= {DW{1'b0}};
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            core_start <= 1'b0;
            core_op    <= 2'b00;
            core_q     <= {DW{1'b0}};
            core_m     <= {DW{1'b0}};
            rsp_valid  <= 1'b0;
            rsp_hi     <= {DW{1'b0}};
            rsp_lo     <= {DW{1'b0}};
            rsp_err    <= 2'b00;
`ifdef MDSR_TIMEOUT_EN
            to_cnt_r     <= {TO_W{1'b0}};
            core_abort_r <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
`ifdef MDSR_TIMEOUT_EN
            core_abort_r <= 1'b0;
`endif
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        op_r      <= req_op;
                        q_r       <= req_q;
                        m_r       <= req_m;
                        core_op   <= req_op;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= S_COND;
                    end
                end
                S_COND: begin
                    if ((op_r == OP_DIV) && (m_r == {DW{1'b0}})) begin
                        rsp_err   <= ERR_DIV0;
                        rsp_hi    <= {DW{1'b0}};
                        rsp_lo    <= {DW{1'b0}};
                        rsp_valid <= 1'b1;
                        state_r   <= S_RESP;
                    end else if (op_r == OP_ILL) begin
                        rsp_err   <= ERR_ILL;
                        rsp_hi    <= {DW{1'b0}};
                        rsp_lo    <= {DW{1'b0}};
                        rsp_valid <= 1'b1;
                        state_r   <= S_RESP;
                    end else begin
                        {core_q, core_m} <= cond_operands(op_r, q_r, m_r);
                        core_start       <= 1'b1;
                        state_r          <= S_START;
                    end
                end
                S_START: begin
`ifdef MDSR_TIMEOUT_EN
                    to_cnt_r <= {TO_W{1'b0}};
`endif
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        rsp_hi    <= core_res_hi;
                        rsp_lo    <= core_res_lo;
                        rsp_err   <= ERR_OK;
                        rsp_valid <= 1'b1;
                        state_r   <= S_RESP;
                    end else begin
`ifdef MDSR_TIMEOUT_EN
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                        if ((to_cnt_r + TO_W'(1)) == TO_W'(TO_CYCLES)) begin
                            core_abort_r <= 1'b1;
                            rsp_hi       <= {DW{1'b0}};
                            rsp_lo       <= {DW{1'b0}};
                            rsp_err      <= ERR_TO;
                            rsp_valid    <= 1'b1;
                            state_r      <= S_RESP;
                        end
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdsr_op_sequencer.sv
// Self-checking bench for mdsr_op_sequencer: scoreboard of expected responses,
// one task per scenario. Timeout scenario follows MDSR_TIMEOUT_EN.
module tb_mdsr_op_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [15:0] req_q = 16'h0000;
    logic [15:0] req_m = 16'h0000;
    logic        core_start;
    logic [1:0]  core_op;
    logic [15:0] core_q, core_m;
    logic        core_done = 1'b0;
    logic [15:0] core_res_hi = 16'h0000;
    logic [15:0] core_res_lo = 16'h0000;
    logic        core_abort;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_hi, rsp_lo;
    logic [1:0]  rsp_err;
    logic        busy;

    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
        logic [1:0]  err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mdsr_op_sequencer #(.DW(16), .TO_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_q(req_q), .req_m(req_m),
        .core_start(core_start), .core_op(core_op), .core_q(core_q), .core_m(core_m),
        .core_done(core_done), .core_res_hi(core_res_hi), .core_res_lo(core_res_lo),
        .core_abort(core_abort),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Waits for req_ready, presents one request and returns #1 after the accepting edge.
    task automatic launch(input logic [1:0] op, input logic [15:0] q, input logic [15:0] m);
        int t = 0;
        while (req_ready !== 1'b1 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin n_errors++; $display("FAIL launch_ready: got %b want 1", req_ready); end
        req_valid = 1'b1; req_op = op; req_q = q; req_m = m;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            n_errors++; $display("FAIL accept_flags: busy=%b req_ready=%b want 1/0", busy, req_ready);
        end
    endtask

    // Called #1 after the accepting edge: checks the start pulse timing and conditioned operands.
    task automatic check_start(input string name, input logic [1:0] op,
                               input logic [15:0] eq, input logic [15:0] em);
        n_checks++;
        if (core_start !== 1'b0) begin n_errors++; $display("FAIL %s_start_early: got %b want 0", name, core_start); end
        @(posedge clk); #1;
        n_checks++;
        if (core_start !== 1'b1) begin n_errors++; $display("FAIL %s_start: got %b want 1", name, core_start); end
        n_checks++;
        if (core_q !== eq || core_m !== em || core_op !== op) begin
            n_errors++;
            $display("FAIL %s_operands: got op=%h q=%h m=%h want op=%h q=%h m=%h", name, core_op, core_q, core_m, op, eq, em);
        end
        @(posedge clk); #1;
        n_checks++;
        if (core_start !== 1'b0) begin n_errors++; $display("FAIL %s_start_pulse: got %b want 0", name, core_start); end
    endtask

    // Core model: after 'delay' cycles returns {hi,lo} with a one-cycle done strobe.
    task automatic finish_core(input string name, input int delay,
                               input logic [15:0] hi, input logic [15:0] lo);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL %s_early_rsp: got %b want 0", name, rsp_valid); end
        end
        exp_q.push_back('{hi: hi, lo: lo, err: 2'b00});
        core_done = 1'b1; core_res_hi = hi; core_res_lo = lo;
        @(posedge clk); #1;
        core_done = 1'b0; core_res_hi = 16'hdead; core_res_lo = 16'hbeef;
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL %s_rsp_latency: got %b want 1", name, rsp_valid); end
    endtask

    // Waits for a response, compares with the scoreboard head, optionally stalls, then consumes it.
    task automatic get_rsp(input string name, input int hold);
        rsp_t e;
        rsp_t first;
        int   t = 0;
        while (rsp_valid !== 1'b1 && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL %s_rsp_timeout: rsp_valid=%b want 1", name, rsp_valid); return; end
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL %s_unexpected_rsp: hi=%h lo=%h err=%b", name, rsp_hi, rsp_lo, rsp_err); return; end
        e = exp_q.pop_front();
        n_checks++;
        if (rsp_hi !== e.hi || rsp_lo !== e.lo || rsp_err !== e.err) begin
            n_errors++;
            $display("FAIL %s_rsp: got hi=%h lo=%h err=%b want hi=%h lo=%h err=%b", name, rsp_hi, rsp_lo, rsp_err, e.hi, e.lo, e.err);
        end
        first = '{hi: rsp_hi, lo: rsp_lo, err: rsp_err};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_hi !== first.hi || rsp_lo !== first.lo || rsp_err !== first.err) begin
                n_errors++;
                $display("FAIL %s_hold: valid=%b req_ready=%b hi=%h lo=%h err=%b want 1/0 %h %h %b",
                         name, rsp_valid, req_ready, rsp_hi, rsp_lo, rsp_err, first.hi, first.lo, first.err);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++; $display("FAIL %s_release: valid=%b req_ready=%b busy=%b want 0/1/0", name, rsp_valid, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || core_start !== 1'b0 || core_abort !== 1'b0 ||
            core_op !== 2'b00 || core_q !== 16'h0 || core_m !== 16'h0 || rsp_valid !== 1'b0 ||
            rsp_hi !== 16'h0 || rsp_lo !== 16'h0 || rsp_err !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_values: req_ready=%b busy=%b start=%b abort=%b op=%h q=%h m=%h valid=%b hi=%h lo=%h err=%b",
                     req_ready, busy, core_start, core_abort, core_op, core_q, core_m, rsp_valid, rsp_hi, rsp_lo, rsp_err);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_swap();
        launch(2'b00, 16'h0003, 16'h0000);
        check_start("mul_swap", 2'b00, 16'h0000, 16'h0003);
        finish_core("mul_swap", 0, 16'h0000, 16'h0000);
        get_rsp("mul_swap", 0);
    endtask

    task automatic test_mul_min_neg();
        launch(2'b00, 16'h8000, 16'h8000);
        check_start("mul_minneg", 2'b00, 16'h0001, 16'h0001);
        finish_core("mul_minneg", 2, 16'h0000, 16'h0001);
        get_rsp("mul_minneg", 0);
    endtask

    task automatic test_mul_plain();
        launch(2'b00, 16'h1234, 16'h0010);
        check_start("mul_plain", 2'b00, 16'h1234, 16'h0010);
        finish_core("mul_plain", 3, 16'h0001, 16'h2340);
        get_rsp("mul_plain", 0);
    endtask

    task automatic test_error(input string name, input logic [1:0] op, input logic [15:0] q,
                              input logic [15:0] m, input logic [1:0] err);
        exp_q.push_back('{hi: 16'h0000, lo: 16'h0000, err: err});
        launch(op, q, m);
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || core_start !== 1'b0) begin
            n_errors++; $display("FAIL %s_latency: valid=%b start=%b want 1/0", name, rsp_valid, core_start);
        end
        get_rsp(name, 2);
    endtask

    task automatic test_sqrt_hold();
        launch(2'b10, 16'h0051, 16'h5555);
        check_start("sqrt", 2'b10, 16'h0051, 16'h0000);
        finish_core("sqrt", 10, 16'h0000, 16'h0009);
        get_rsp("sqrt", 5);
    endtask

    task automatic test_long_wait();
        launch(2'b01, 16'h0064, 16'h0007);
        check_start("longwait", 2'b01, 16'h0064, 16'h0007);
`ifdef MDSR_TIMEOUT_EN
        exp_q.push_back('{hi: 16'h0000, lo: 16'h0000, err: 2'b11});
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (core_abort !== (i == 64)) begin
                n_errors++; $display("FAIL timeout_abort_cycle%0d: got %b want %b", i, core_abort, (i == 64));
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (core_abort !== 1'b0) begin n_errors++; $display("FAIL timeout_abort_pulse: got %b want 0", core_abort); end
        get_rsp("timeout", 0);
`else
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || busy !== 1'b1 || core_abort !== 1'b0) begin
                n_checks++; n_errors++;
                $display("FAIL no_timeout_cycle%0d: valid=%b busy=%b abort=%b want 0/1/0", i, rsp_valid, busy, core_abort);
                break;
            end
        end
        n_checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            n_errors++; $display("FAIL no_timeout_still_wait: busy=%b valid=%b want 1/0", busy, rsp_valid);
        end
        finish_core("longwait", 0, 16'h0002, 16'h000e);
        get_rsp("longwait", 0);
`endif
    endtask

    task automatic test_reset_in_wait();
        launch(2'b10, 16'h0051, 16'h0000);
        check_start("rstwait", 2'b10, 16'h0051, 16'h0000);
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || core_start !== 1'b0 || core_abort !== 1'b0 ||
            core_op !== 2'b00 || core_q !== 16'h0 || core_m !== 16'h0 || rsp_valid !== 1'b0 ||
            rsp_hi !== 16'h0 || rsp_lo !== 16'h0 || rsp_err !== 2'b00) begin
            n_errors++;
            $display("FAIL async_reset_values: req_ready=%b busy=%b op=%h q=%h m=%h valid=%b",
                     req_ready, busy, core_op, core_q, core_m, rsp_valid);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b1; core_res_hi = 16'h0000; core_res_lo = 16'h0009;
        @(posedge clk); #1;
        core_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_errors++; $display("FAIL stale_done_cycle%0d: valid=%b busy=%b want 0/0", i, rsp_valid, busy);
            end
        end
        launch(2'b00, 16'h0002, 16'h0003);
        check_start("after_reset", 2'b00, 16'h0002, 16'h0003);
        finish_core("after_reset", 1, 16'h0000, 16'h0006);
        get_rsp("after_reset", 0);
    endtask

    task automatic test_back_to_back();
        launch(2'b00, 16'h00ff, 16'h0002);
        check_start("b2b_a", 2'b00, 16'h00ff, 16'h0002);
        finish_core("b2b_a", 0, 16'h0000, 16'h01fe);
        get_rsp("b2b_a", 0);
        launch(2'b01, 16'h0064, 16'h000a);
        check_start("b2b_b", 2'b01, 16'h0064, 16'h000a);
        finish_core("b2b_b", 0, 16'h0000, 16'h000a);
        get_rsp("b2b_b", 0);
    endtask

    initial begin
        test_reset();
        test_mul_swap();
        test_mul_min_neg();
        test_mul_plain();
        test_error("div0", 2'b01, 16'h1234, 16'h0000, 2'b01);
        test_error("illegal", 2'b11, 16'h0005, 16'h0006, 2'b10);
        test_sqrt_hold();
        test_long_wait();
        test_reset_in_wait();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
